// File: rtl/shader_instr_memory.sv
// rtl/shader_instr_memory.sv - shader program store: SPI-fed shift loading, per-pixel replay stream
module shader_instr_memory #(
    parameter int unsigned                       NUM_INSTR      = 16,
    parameter int unsigned                       INSTR_W        = 8,
    parameter logic [NUM_INSTR*INSTR_W-1:0]      INSTR_DEFAULTS = '0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [INSTR_W-1:0] load_instr_i,
    output logic [INSTR_W-1:0] echo_instr_o,
    input  logic               start_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               last_o,
    output logic               done_o,
    output logic               busy_o,
    output logic               overflow_o
);
    localparam int unsigned          PTR_W    = $clog2(NUM_INSTR);
    localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(NUM_INSTR - 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] mem_q [NUM_INSTR];
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               pending_q, pending_d;
    logic [INSTR_W-1:0] pend_byte_q, pend_byte_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;
    logic               shift_en;
    logic [INSTR_W-1:0] shift_byte;
    logic               xfer;
    logic               at_last;

    assign xfer    = (state_q == RUN) && ready_i;
    assign at_last = (ptr_q == LAST_PTR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            pending_q   <= 1'b0;
            pend_byte_q <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < NUM_INSTR; i++) begin
                mem_q[i] <= INSTR_DEFAULTS[i*INSTR_W +: INSTR_W];
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            pending_q   <= pending_d;
            pend_byte_q <= pend_byte_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
            if (shift_en) begin
                for (int i = 0; i < NUM_INSTR - 1; i++) begin
                    mem_q[i] <= mem_q[i+1];
                end
                mem_q[NUM_INSTR-1] <= shift_byte;
            end
        end
    end

    // A pending load must drain before a new pass may start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!pending_q && start_i) state_d = RUN;
            RUN:  if (xfer && at_last)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        pending_d   = pending_q;
        pend_byte_d = pend_byte_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;
        shift_en    = 1'b0;
        shift_byte  = load_instr_i;
        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    shift_en   = 1'b1;
                    shift_byte = pend_byte_q;
                    pending_d  = load_i;
                    if (load_i) pend_byte_d = load_instr_i;
                end else begin
                    shift_en = load_i;
                    if (start_i) ptr_d = '0;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (at_last) begin
                        ptr_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
                // The program is frozen while it streams; loads wait in a single-entry slot.
                if (load_i) begin
                    pending_d   = 1'b1;
                    pend_byte_d = load_instr_i;
                    if (pending_q) overflow_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign echo_instr_o = mem_q[0];
    assign instr_o      = mem_q[ptr_q];
    assign valid_o      = (state_q == RUN);
    assign last_o       = valid_o && at_last;
    assign done_o       = done_q;
    assign busy_o       = valid_o || pending_q;
    assign overflow_o   = overflow_q;
endmodule
